// File: rtl/trng_postproc.sv
// TRNG post-processing: parity fold of TDC codes, von Neumann debiasing, byte packing,
// FWFT byte FIFO and a sticky repetition-count health test that blocks output.
module trng_postproc #(
  parameter int FIFO_DEPTH = 16,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [7:0]                    sample_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rct_alarm,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic          s1_valid_reg, s1_bit_reg;
  logic [7:0]    prev_sample_reg;
  logic [7:0]    rep_cnt_reg, rep_cnt_next;
  logic          rct_alarm_reg, alarm_set, block;
  logic          half_reg, first_reg;
  logic [7:0]    pack_reg;
  logic [2:0]    pack_cnt_reg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          overflow_reg;
  logic          vn_valid, byte_done, wr_req, wr_en, pop, full, empty;
  logic [7:0]    byte_val;

  // Repetition count; rep_cnt of 0 marks "no previous sample since reset".
  always_comb begin
    rep_cnt_next = rep_cnt_reg;
    if (enable) begin
      if (rep_cnt_reg == 8'd0 || sample_in != prev_sample_reg)
        rep_cnt_next = 8'd1;
      else if (rep_cnt_reg != 8'hFF)
        rep_cnt_next = rep_cnt_reg + 8'd1;
    end
  end

  assign alarm_set = enable && (int'(rep_cnt_next) >= RCT_CUTOFF);
  assign block     = rct_alarm_reg | alarm_set;

  // Second bit of a pair that differs from the first emits the first bit.
  assign vn_valid  = s1_valid_reg & half_reg & (first_reg != s1_bit_reg);
  assign byte_done = vn_valid & (pack_cnt_reg == 3'd7);
  assign byte_val  = {pack_reg[6:0], first_reg};

  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop    = ~empty & out_ready;
  assign wr_req = byte_done & ~block;
  assign wr_en  = wr_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg    <= 1'b0;
      s1_bit_reg      <= 1'b0;
      prev_sample_reg <= 8'h00;
      rep_cnt_reg     <= 8'd0;
      rct_alarm_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= enable;
      if (enable) begin
        s1_bit_reg      <= ^sample_in;
        prev_sample_reg <= sample_in;
        rep_cnt_reg     <= rep_cnt_next;
      end
      if (alarm_set)
        rct_alarm_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || block) begin
      half_reg     <= 1'b0;
      first_reg    <= 1'b0;
      pack_reg     <= 8'h00;
      pack_cnt_reg <= 3'd0;
    end else if (s1_valid_reg) begin
      if (!half_reg) begin
        first_reg <= s1_bit_reg;
        half_reg  <= 1'b1;
      end else begin
        half_reg <= 1'b0;
        if (vn_valid) begin
          pack_reg     <= byte_val;
          pack_cnt_reg <= pack_cnt_reg + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_req && full && !pop)
        overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[wr_ptr_reg[AW-1:0]] <= byte_val;
  end

  // Head byte is read combinationally so it is visible in the cycle after the write.
  assign out_data   = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
  assign out_valid  = ~empty;
  assign fifo_level = wr_ptr_reg - rd_ptr_reg;
  assign rct_alarm  = rct_alarm_reg;
  assign overflow   = overflow_reg;
endmodule

// File: tb/tb_trng_postproc.sv
// Directed self-checking bench for trng_postproc with hand-computed expectations.
module tb_trng_postproc;
  logic       clk = 1'b0;
  logic       rst, enable, out_ready;
  logic [7:0] sample_in;
  logic [7:0] out_data;
  logic       out_valid, rct_alarm, overflow;
  logic [4:0] fifo_level;
  int         n_tests = 0;
  int         n_fail  = 0;

  trng_postproc #(.FIFO_DEPTH(16), .RCT_CUTOFF(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .rct_alarm(rct_alarm), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else
      $display("ok   %s: 0x%0h", tag, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] code);
    enable    = 1'b1;
    sample_in = code;
    tick();
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) tick();
  endtask

  // 16 samples, raw 1,0 pairs -> eight 1 bits -> 0xFF
  task automatic send_ff();
    for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 8'h01 : 8'h00);
  endtask

  // Pairs 10,01 repeated -> bits 1,0,... -> 0xAA
  task automatic send_aa();
    for (int i = 0; i < 4; i++) begin
      send(8'h01); send(8'h00); send(8'h00); send(8'h01);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    rst    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; sample_in = 8'h00; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_alarm", rct_alarm, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", out_data, 8'h00);

    // Latency: byte appears two edges after its 16th sample
    out_ready = 1'b1;
    send_ff();
    check("lat_e0_valid", out_valid, 0);
    idle(1);
    check("lat_e1_valid", out_valid, 1);
    check("lat_e1_data", out_data, 8'hFF);
    check("lat_e1_level", fifo_level, 1);
    idle(1);
    check("lat_pop_valid", out_valid, 0);
    check("lat_ovf", overflow, 0);

    // 00/11 pairs only: nothing extracted
    for (int i = 0; i < 4; i++) begin
      send(8'h03); send(8'h0F); send(8'h01); send(8'h07);
    end
    idle(2);
    check("same_valid", out_valid, 0);
    check("same_level", fifo_level, 0);

    // Two 0xAA bytes held with out_ready low, then popped one by one
    out_ready = 1'b0;
    send_aa(); send_aa();
    idle(1);
    check("aa_level", fifo_level, 2);
    check("aa_data0", out_data, 8'hAA);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("aa_pop_level", fifo_level, 1);
    check("aa_data1", out_data, 8'hAA);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("aa_empty", out_valid, 0);

    // Overflow: 17 bytes into a 16-deep FIFO, then a write coinciding with a pop
    for (int i = 0; i < 17; i++) send_ff();
    idle(1);
    check("full_level", fifo_level, 16);
    check("full_ovf", overflow, 1);
    send_aa();
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    check("wr_pop_level", fifo_level, 16);
    out_ready = 1'b1; idle(15); out_ready = 1'b0;
    check("drain_level", fifo_level, 1);
    check("drain_tail", out_data, 8'hAA);

    // Repetition-count alarm
    do_reset();
    check("rst2_ovf", overflow, 0);
    send_ff();
    for (int i = 0; i < 31; i++) send(8'h5A);
    check("rct_31", rct_alarm, 0);
    check("rct_pre_level", fifo_level, 1);
    send(8'h5A);
    check("rct_32", rct_alarm, 1);
    send_ff(); send_ff();
    idle(1);
    check("rct_blocked_level", fifo_level, 1);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    check("rct_drain_valid", out_valid, 0);
    check("rct_sticky", rct_alarm, 1);

    // Reset mid-byte with three bytes queued
    do_reset();
    check("rst3_alarm", rct_alarm, 0);
    send_ff(); send_ff(); send_ff();
    for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 8'h01 : 8'h00);
    check("mid_level", fifo_level, 3);
    rst = 1'b1; enable = 1'b1; sample_in = 8'h01;
    tick();
    rst = 1'b0; enable = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_alarm", rct_alarm, 0);
    check("mid_rst_ovf", overflow, 0);
    send_aa();
    idle(1);
    check("fresh_level", fifo_level, 1);
    check("fresh_data", out_data, 8'hAA);
    idle(4);
    check("fresh_only_one", fifo_level, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trng_postproc.md
# trng_postproc

Post-processing stage placed directly downstream of the carry-chain TDC entropy source. Each cycle it takes the 8-bit TDC code and folds it to one raw bit by parity. It then removes bias with a von Neumann extractor, packs the debiased bits into bytes and buffers them in a first-word-fall-through FIFO behind a valid/ready interface. A repetition-count health test on the raw TDC codes blocks output when the source appears stuck.

## Interface
- FIFO_DEPTH, 16: byte FIFO depth; power of two, 4 to 256.
- RCT_CUTOFF, 32: number of consecutive identical TDC codes that trips the alarm; 2 to 255.
- clk  in  1  single clock; same domain as the TDC sampling flops.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = accept samples; 0 = ignore samples and hold all state.
- sample_in  in  8  TDC thermometer-decoded code; one new value every cycle.
- out_data  out  8  head-of-FIFO byte; valid while out_valid = 1.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data on a cycle where out_valid & out_ready.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- rct_alarm  out  1  sticky repetition-count alarm.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.

## Operation
- Sample acceptance: a sample is accepted on each clk edge where enable = 1. Accepted samples feed both the raw-bit path and the health test.
- Raw bit: raw = XOR of sample_in[7:0], registered as stage S1 together with a valid flag.
- Von Neumann extractor: a pair register holds the first bit of each pair plus a half flag.
  - On the second bit of a pair: 01 -> 0, 10 -> 1; 00 and 11 produce nothing.
  - The half flag clears after every second bit, whether or not a bit is produced.
- Packer: an 8-bit shift register shifts left, taking the new bit into bit 0, plus a 3-bit count.
  - When the 8th bit arrives, the completed byte is written to the FIFO and the count returns to 0.
  - The first extracted bit ends up in out_data[7].
- FIFO:
  - Pointer width is log2(FIFO_DEPTH)+1; the wrap bit distinguishes full from empty.
  - The write pointer increments on write and the read pointer on pop; both wrap naturally.
- Write refused:
  - If the FIFO is full and there is no simultaneous pop, the byte is discarded, overflow is set and the packer still restarts.
  - If the FIFO is full with a simultaneous pop, both the write and the pop occur, and the level is unchanged.
- Health test (repetition count):
  - Compare each accepted sample with the previous accepted sample. Equal -> rep_cnt increments, saturating at 255; different -> rep_cnt = 1.
  - rct_alarm is set on the edge where rep_cnt would reach RCT_CUTOFF.
  - While rct_alarm = 1, no FIFO writes occur and the extractor/packer are held cleared. FIFO contents can still be popped.
  - rct_alarm clears only on rst.
- enable = 0: samples are ignored, every register holds, and S1 valid is 0 on the next cycle. The FIFO still drains.
- Reset values: out_valid 0, fifo_level 0, rct_alarm 0, overflow 0, out_data 0.
  - Internally: pointers 0, packer count 0, half flag 0, rep_cnt 0. The first accepted sample sets rep_cnt = 1.
- Reset mid-operation: partial pair, partial byte and FIFO contents are discarded, and rep_cnt restarts.

## Timing
- Edge E0: sample accepted and registered into S1.
- Edge E1: the pair/extractor decision is made and the bit is shifted into the packer. If it is the 8th bit, the byte is written to the FIFO on this same edge.
- After E1: out_valid = 1 and out_data shows the byte (FWFT).
- Latency: 2 edges from accepting the sample that completes a byte to out_valid high.
- Throughput: at most 1 bit per 2 samples, i.e. at most 1 byte per 16 accepted samples.
- Pop: on the edge where out_valid & out_ready, the next byte appears in the following cycle, or out_valid drops if the FIFO is now empty.
- fifo_level updates on the same edge as the write or pop.
- rct_alarm:
  - Rises on the edge that accepts the RCT_CUTOFF-th identical sample.
  - A byte completing on that same edge is not written (the alarm has priority).
- Reset: the rst edge overrides enable and any FIFO writes or pops in that cycle.

## Test plan
- Alternating codes 0x01, 0x00 (raw 1,0 -> bit 1), enable = 1, out_ready = 1, 16 samples -> one byte 0xFF; out_valid high 2 edges after the 16th sample; no overflow.
- Codes 0x03 repeated as raw 0, interleaved with 0x07/0x0F to avoid an alarm, so that every pair is 00 or 11 -> no bytes, out_valid stays 0, fifo_level 0.
- Pair pattern 10,01 repeated (bits 1,0), 16 pairs, out_ready = 0 -> out_data = 0xAA, 0xAA; fifo_level = 2.
- out_ready = 0 with FIFO_DEPTH+1 bytes generated -> fifo_level = FIFO_DEPTH, overflow = 1. Then a byte completes on a pop cycle -> the write is accepted and fifo_level is unchanged.
- Constant code 0x5A, RCT_CUTOFF = 32 -> rct_alarm rises on the 32nd sample edge and no further writes occur. The FIFO still drains to out_valid = 0. The alarm persists until rst.
- Assert rst mid-byte with 3 bytes queued -> next cycle out_valid 0, fifo_level 0, flags 0. A fresh 16-sample pattern then yields exactly one correct byte.
